// File: rtl/ard_link_pkg.sv
// Shared types for the core-to-Arduino byte link: FSM states, transfer tags, widths.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package ard_link_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 16;

  typedef enum logic [3:0] {
    IDLE,
    W_HI,
    W_HI_REL,
    W_LO,
    W_LO_REL,
    R_HI,
    R_HI_REL,
    R_LO,
    R_LO_REL
  } link_state_t;

  // Encoding 0 is reserved on the core side and is carried as MDR.
  typedef enum logic [1:0] {
    TAG_RSVD = 2'd0,
    TAG_PC   = 2'd1,
    TAG_MAR  = 2'd2,
    TAG_MDR  = 2'd3
  } link_tag_t;

  typedef struct packed {
    logic pc;
    logic mar;
    logic mdr;
  } tag_oh_t;

  function automatic tag_oh_t tag_onehot(input logic [1:0] tag);
    tag_oh_t oh;
    oh = '0;
    case (tag)
      TAG_PC:  oh.pc  = 1'b1;
      TAG_MAR: oh.mar = 1'b1;
      default: oh.mdr = 1'b1;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/ard_sync.sv
// Multi-flop level synchronizer for one asynchronous Arduino handshake line.
// Latency: SYNC_STAGES cycles from sampling to q.
// Backpressure: none; free-running, cleared by async active-low reset.
module ard_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] ff;

  // Shift the raw level through the flop chain; reset clears every stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ff <= '0;
    else      ff <= {ff[SYNC_STAGES-2:0], d};
  end

  assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/ard_bus_link.sv
// Moves 16-bit core words over the 8-bit Arduino pin bus, high byte first, four-phase handshake.
// Latency: 4*(SYNC_STAGES+1) cycles accept-to-idle with an instant Arduino; all outputs registered.
// Backpressure: req_ready only in IDLE; waits on Arduino ready lines (watchdog with ARD_LINK_TIMEOUT_EN).
module ard_bus_link
  import ard_link_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_tag,
  input  logic [WORD_W-1:0] req_data,
  output logic              rsp_valid,
  output logic [WORD_W-1:0] rsp_data,
  output logic              err,
  output logic [BYTE_W-1:0] out_bus,
  output logic              out_valid,
  input  logic [BYTE_W-1:0] in_bus,
  output logic              bus_pc,
  output logic              bus_mar,
  output logic              bus_mdr,
  input  logic              ard_receive_ready,
  input  logic              ard_data_ready
);

  link_state_t       state, state_nxt;
  logic [WORD_W-1:0] wdata, wdata_nxt;
  logic [WORD_W-1:0] rword, rword_nxt;
  logic              arm, arm_nxt;
  tag_oh_t           tags, tags_nxt;
  logic              req_ready_nxt, out_valid_nxt, rsp_valid_nxt, err_nxt;
  logic [BYTE_W-1:0] out_bus_nxt;
  logic [WORD_W-1:0] rsp_data_nxt;
  logic              rr_s, dr_s;
  logic              tmo;

  ard_sync #(.SYNC_STAGES(SYNC_STAGES)) u_rr_sync (
    .clk (clk),
    .rst (rst),
    .d   (ard_receive_ready),
    .q   (rr_s)
  );

  ard_sync #(.SYNC_STAGES(SYNC_STAGES)) u_dr_sync (
    .clk (clk),
    .rst (rst),
    .d   (ard_data_ready),
    .q   (dr_s)
  );

`ifdef ARD_LINK_TIMEOUT_EN
  localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] phase_cnt;

  // Per-phase watchdog: restarts on every state change, saturates at the limit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   phase_cnt <= '0;
    else if (state_nxt != state) phase_cnt <= '0;
    else if (phase_cnt != TMO_LAST) phase_cnt <= phase_cnt + 1'b1;
  end

  assign tmo = (state != IDLE) && (phase_cnt == TMO_LAST);
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYCLES != 0);
  assign tmo        = 1'b0;
`endif

  // State and transfer context registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      wdata <= '0;
      rword <= '0;
      arm   <= 1'b0;
      tags  <= '0;
    end else begin
      state <= state_nxt;
      wdata <= wdata_nxt;
      rword <= rword_nxt;
      arm   <= arm_nxt;
      tags  <= tags_nxt;
    end
  end

  // Next state plus next value of every registered output.
  always_comb begin
    state_nxt     = state;
    wdata_nxt     = wdata;
    rword_nxt     = rword;
    arm_nxt       = arm;
    tags_nxt      = tags;
    rsp_valid_nxt = 1'b0;
    rsp_data_nxt  = rsp_data;
    err_nxt       = 1'b0;

    case (state)
      IDLE: begin
        if (req_valid) begin
          wdata_nxt = req_data;
          tags_nxt  = tag_onehot(req_tag);
          // An ack already high at accept is stale; the HI phase must see it low first.
          arm_nxt   = req_write ? !rr_s : !dr_s;
          state_nxt = req_write ? W_HI : R_HI;
        end
      end
      W_HI: begin
        if (!rr_s) arm_nxt = 1'b1;
        if (arm && rr_s) state_nxt = W_HI_REL;
      end
      W_HI_REL: if (!rr_s) state_nxt = W_LO;
      W_LO:     if (rr_s)  state_nxt = W_LO_REL;
      W_LO_REL: if (!rr_s) state_nxt = IDLE;
      R_HI: begin
        if (!dr_s) arm_nxt = 1'b1;
        if (arm && dr_s) begin
          rword_nxt[WORD_W-1:BYTE_W] = in_bus;
          state_nxt = R_HI_REL;
        end
      end
      R_HI_REL: if (!dr_s) state_nxt = R_LO;
      R_LO: begin
        if (dr_s) begin
          rword_nxt[BYTE_W-1:0] = in_bus;
          state_nxt = R_LO_REL;
        end
      end
      R_LO_REL: begin
        if (!dr_s) begin
          state_nxt     = IDLE;
          rsp_valid_nxt = 1'b1;
          rsp_data_nxt  = rword;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Watchdog abort overrides whatever the phase decided; no response is produced.
    if (tmo) begin
      state_nxt     = IDLE;
      err_nxt       = 1'b1;
      rsp_valid_nxt = 1'b0;
      rsp_data_nxt  = rsp_data;
    end

    if (state_nxt == IDLE) tags_nxt = '0;

    req_ready_nxt = (state_nxt == IDLE);
    out_valid_nxt = (state_nxt inside {W_HI, W_LO, R_HI, R_LO});
    case (state_nxt)
      W_HI:    out_bus_nxt = wdata_nxt[WORD_W-1:BYTE_W];
      W_LO:    out_bus_nxt = wdata_nxt[BYTE_W-1:0];
      default: out_bus_nxt = '0;
    endcase
  end

  // Output registers; reset forces every output low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_ready <= 1'b0;
      out_valid <= 1'b0;
      out_bus   <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      err       <= 1'b0;
    end else begin
      req_ready <= req_ready_nxt;
      out_valid <= out_valid_nxt;
      out_bus   <= out_bus_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_data  <= rsp_data_nxt;
      err       <= err_nxt;
    end
  end

  assign bus_pc  = tags.pc;
  assign bus_mar = tags.mar;
  assign bus_mdr = tags.mdr;

endmodule

// File: tb/tb_ard_bus_link.sv
// Scoreboard bench for ard_bus_link with a behavioural Arduino on the handshake lines.
// Latency: checks accept-to-idle cycle counts for instant and slow Arduino responses.
// Backpressure: bench waits on req_ready / out_valid with bounded loops.
module tb_ard_bus_link;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_tag = 2'd0;
  logic [15:0] req_data = 16'd0;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        err;
  logic [7:0]  out_bus;
  logic        out_valid;
  logic [7:0]  in_bus = 8'd0;
  logic        bus_pc, bus_mar, bus_mdr;
  logic        ard_receive_ready = 1'b0;
  logic        ard_data_ready = 1'b0;

  ard_bus_link #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(16)) dut (
    .clk               (clk),
    .rst               (rst),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_write         (req_write),
    .req_tag           (req_tag),
    .req_data          (req_data),
    .rsp_valid         (rsp_valid),
    .rsp_data          (rsp_data),
    .err               (err),
    .out_bus           (out_bus),
    .out_valid         (out_valid),
    .in_bus            (in_bus),
    .bus_pc            (bus_pc),
    .bus_mar           (bus_mar),
    .bus_mdr           (bus_mdr),
    .ard_receive_ready (ard_receive_ready),
    .ard_data_ready    (ard_data_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int t0 = 0;
  int n_chk = 0;
  int n_pass = 0;
  int n_rsp = 0;
  int n_err = 0;
  logic [7:0]  byte_q[$];
  logic [7:0]  rd_q[$];
  logic [15:0] rsp_q[$];
  logic [15:0] rsp_exp;
  logic [30:0] all_outs;

  assign all_outs = {req_ready, out_valid, out_bus, bus_pc, bus_mar, bus_mdr, rsp_valid, err, rsp_data};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  function automatic logic [2:0] exp_oh(input logic [1:0] tag);
    case (tag)
      2'd1:    return 3'b100;
      2'd2:    return 3'b010;
      default: return 3'b001;
    endcase
  endfunction

  // Response scoreboard: every rsp_valid cycle must match the oldest expected word.
  always @(negedge clk) begin
    if (rst && rsp_valid) begin
      n_rsp++;
      if (rsp_q.size() > 0) begin
        rsp_exp = rsp_q.pop_front();
        check_eq("rsp_data", rsp_data, rsp_exp);
      end else begin
        check_eq("rsp_unexpected", rsp_valid, 1'b0);
      end
    end
  end

  always @(negedge clk) if (rst && err) n_err++;

  task automatic wait_ov(input logic lvl, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (out_valid === lvl) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_ready(input int exp_lat, input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (req_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq({tag, "_idle"}, ok, 1'b1);
    if (exp_lat >= 0) check_eq({tag, "_lat"}, cyc - t0, exp_lat);
  endtask

  task automatic send_req(input bit wr, input logic [1:0] tag, input logic [15:0] dat);
    @(negedge clk);
    check_eq("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1;
    req_write = wr;
    req_tag   = tag;
    req_data  = dat;
    if (wr) begin
      byte_q.push_back(dat[15:8]);
      byte_q.push_back(dat[7:0]);
    end else begin
      rd_q.push_back(dat[15:8]);
      rd_q.push_back(dat[7:0]);
      rsp_q.push_back(dat);
    end
    @(posedge clk);
    #1;
    t0 = cyc;
    req_valid = 1'b0;
    check_eq("accept_ready_low", req_ready, 1'b0);
    check_eq("accept_tag", {bus_pc, bus_mar, bus_mdr}, exp_oh(tag));
  endtask

  // One byte phase of the Arduino: answer out_valid after dly cycles, release after dly cycles.
  task automatic ard_phase(input bit wr, input int dly, input logic [2:0] oh);
    bit ok;
    logic [7:0] b;
    wait_ov(1'b1, ok);
    check_eq("ov_rise", ok, 1'b1);
    repeat (dly) @(negedge clk);
    check_eq("tag_byte", {bus_pc, bus_mar, bus_mdr}, oh);
    b = 8'hxx;
    if (wr) begin
      if (byte_q.size() > 0) b = byte_q.pop_front();
      check_eq("wr_byte", out_bus, b);
      ard_receive_ready = 1'b1;
    end else begin
      check_eq("rd_bus_zero", out_bus, 8'h00);
      if (rd_q.size() > 0) b = rd_q.pop_front();
      in_bus = b;
      ard_data_ready = 1'b1;
    end
    wait_ov(1'b0, ok);
    check_eq("ov_fall", ok, 1'b1);
    check_eq("tag_rel", {bus_pc, bus_mar, bus_mdr}, oh);
    repeat (dly) @(negedge clk);
    if (wr) ard_receive_ready = 1'b0;
    else    ard_data_ready = 1'b0;
  endtask

  task automatic run_xfer(input bit wr, input logic [1:0] tag, input logic [15:0] dat,
                          input int dly, input int exp_lat, input string name);
    send_req(wr, tag, dat);
    ard_phase(wr, dly, exp_oh(tag));
    ard_phase(wr, dly, exp_oh(tag));
    wait_ready(exp_lat, name);
    check_eq({name, "_tags_idle"}, {bus_pc, bus_mar, bus_mdr}, 3'b000);
  endtask

  initial begin
    bit ok;
    #3;
    check_eq("reset_outs", all_outs, 31'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("ready_after_release", req_ready, 1'b1);

    // Write 0xBEEF as MAR with an instant Arduino.
    run_xfer(1'b1, 2'd2, 16'hBEEF, 0, 12, "wr_beef");

    // Read 0x1234 as PC.
    run_xfer(1'b0, 2'd1, 16'h1234, 0, 12, "rd_1234");

    // Stale high acknowledge before the request must be ignored.
    ard_receive_ready = 1'b1;
    repeat (4) @(negedge clk);
    send_req(1'b1, 2'd3, 16'hA55A);
    repeat (6) @(negedge clk);
    check_eq("stale_ov_held", out_valid, 1'b1);
    check_eq("stale_bus_hi", out_bus, 8'hA5);
    ard_receive_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("stale_still_hi", out_valid, 1'b1);
    ard_phase(1'b1, 0, 3'b001);
    ard_phase(1'b1, 0, 3'b001);
    wait_ready(-1, "stale");
    check_eq("rsp_data_held", rsp_data, 16'h1234);

    // Slow Arduino, 7 extra cycles per phase, reserved tag carried as MDR.
    run_xfer(1'b1, 2'd0, 16'hC3E1, 7, 40, "wr_slow");

    // Back-to-back read immediately after, slow Arduino.
    run_xfer(1'b0, 2'd2, 16'hFACE, 7, 40, "rd_slow");

    // Reset during W_LO_REL drops the transfer and clears everything.
    send_req(1'b1, 2'd2, 16'hABCD);
    ard_phase(1'b1, 0, 3'b010);
    wait_ov(1'b1, ok);
    check_eq("rst_lo_rise", ok, 1'b1);
    if (byte_q.size() > 0) check_eq("rst_lo_byte", out_bus, byte_q.pop_front());
    ard_receive_ready = 1'b1;
    wait_ov(1'b0, ok);
    check_eq("rst_lo_fall", ok, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("midreset_outs", all_outs, 31'd0);
    ard_receive_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("midreset_held", all_outs, 31'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("ready_after_midreset", req_ready, 1'b1);
    run_xfer(1'b1, 2'd1, 16'h0001, 0, 12, "wr_0001");

`ifdef ARD_LINK_TIMEOUT_EN
    // No acknowledge at all: watchdog aborts 16 cycles into W_HI.
    send_req(1'b1, 2'd2, 16'h5555);
    byte_q.delete();
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (err === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq("tmo_err_seen", ok, 1'b1);
    check_eq("tmo_lat", cyc - t0, 16);
    check_eq("tmo_outs", {req_ready, out_valid, bus_pc, bus_mar, bus_mdr, rsp_valid}, 6'b100000);
    repeat (20) @(negedge clk);
    check_eq("tmo_err_count", n_err, 1);
`endif

    repeat (5) @(negedge clk);
    check_eq("rsp_count", n_rsp, 2);
    check_eq("rsp_q_empty", rsp_q.size(), 0);
    check_eq("byte_q_empty", byte_q.size(), 0);
`ifdef ARD_LINK_TIMEOUT_EN
    check_eq("err_total", n_err, 1);
`else
    check_eq("err_total", n_err, 0);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish before 200000");
    $fatal(1);
  end

endmodule
